// File: rtl/core_commit_pkg.sv
// Shared types and default constants for the Selen retire stage.
// Record types here are sized for the default 32-bit datapath.
package core_commit_pkg;

    localparam int CC_XLEN         = 32;
    localparam int TRACE_DEPTH_DEF = 4;
    localparam int WDOG_LIMIT_DEF  = 1024;
    localparam int WDOG_W_DEF      = 16;

    typedef struct packed {
        logic [CC_XLEN-1:0] pc;
        logic [31:0]        instr;
        logic [4:0]         rd;
        logic               rd_we;
        logic [CC_XLEN-1:0] data;
        logic               excp;
    } commit_rec_t;

    typedef struct packed {
        logic [CC_XLEN-1:0] pc;
        logic [31:0]        instr;
    } trace_rec_t;

    typedef enum logic [1:0] {
        WDOG_IDLE = 2'd0,
        WDOG_RUN  = 2'd1,
        WDOG_HANG = 2'd2
    } wdog_state_e;

endpackage

// File: rtl/core_commit_fifo.sv
// Synchronous FIFO for trace records; the head is read combinationally
// from storage, and a push into a full FIFO is accepted only with a pop.
module core_commit_fifo
    import core_commit_pkg::*;
#(
    parameter type rec_t = trace_rec_t,
    parameter int  DEPTH = TRACE_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t wdata,
    input  logic pop,
    output rec_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    rec_t           mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           wr_en;
    logic           rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // When full, the slot being written is the one leaving through the head.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign rdata = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/core_commit_stage.sv
// Retire stage: commit record register, instret counter, no-commit
// watchdog and a trace FIFO fed from the commit register.
module core_commit_stage
    import core_commit_pkg::*;
#(
    parameter int XLEN        = CC_XLEN,
    parameter int TRACE_DEPTH = TRACE_DEPTH_DEF,
    parameter int WDOG_LIMIT  = WDOG_LIMIT_DEF,
    parameter int WDOG_W      = WDOG_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_val,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [31:0]     wb_instr,
    input  logic [4:0]      wb_rd,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_excp,
    input  logic            flush,
    output logic            commit_val,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_instr,
    output logic [4:0]      commit_rd,
    output logic            commit_rd_we,
    output logic [XLEN-1:0] commit_data,
    output logic            commit_excp,
    output logic [63:0]     instret,
    output logic            hang,
    output logic            trace_val,
    input  logic            trace_rdy,
    output logic [XLEN-1:0] trace_pc,
    output logic [31:0]     trace_instr,
    output logic            trace_ovf
);

    // Record layouts follow XLEN rather than the package default width.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] data;
        logic            excp;
    } commit_rec_x_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } trace_rec_x_t;

    logic           ret;
    logic           commit_val_reg;
    commit_rec_x_t  commit_rec_reg;
    logic [63:0]    instret_reg;
    wdog_state_e    wdog_state_reg, wdog_state_next;
    logic [WDOG_W-1:0] wdog_cnt_reg, wdog_cnt_next;
    logic           trace_ovf_reg;

    trace_rec_x_t   fifo_wdata;
    trace_rec_x_t   fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;

    assign ret = wb_val & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_val_reg <= 1'b0;
            commit_rec_reg <= '0;
        end else begin
            commit_val_reg <= ret;
            if (ret) begin
                commit_rec_reg.pc    <= wb_pc;
                commit_rec_reg.instr <= wb_instr;
                commit_rec_reg.rd    <= wb_rd;
                commit_rec_reg.rd_we <= wb_rd_we & ~wb_excp;
                commit_rec_reg.data  <= wb_data;
                commit_rec_reg.excp  <= wb_excp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_reg <= '0;
        end else if (ret) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_state_reg <= WDOG_IDLE;
            wdog_cnt_reg   <= '0;
        end else begin
            wdog_state_reg <= wdog_state_next;
            wdog_cnt_reg   <= wdog_cnt_next;
        end
    end

    // Trips on the idle cycle that brings the counter to WDOG_LIMIT-1.
    always_comb begin
        wdog_state_next = wdog_state_reg;
        wdog_cnt_next   = wdog_cnt_reg;
        unique case (wdog_state_reg)
            WDOG_IDLE: begin
                if (ret) begin
                    wdog_state_next = WDOG_RUN;
                    wdog_cnt_next   = '0;
                end
            end
            WDOG_RUN: begin
                if (ret) begin
                    wdog_cnt_next = '0;
                end else begin
                    wdog_cnt_next = wdog_cnt_reg + 1'b1;
                    if (wdog_cnt_reg == WDOG_W'(WDOG_LIMIT - 2)) begin
                        wdog_state_next = WDOG_HANG;
                    end
                end
            end
            WDOG_HANG: begin
                wdog_state_next = WDOG_HANG;
            end
            default: begin
                wdog_state_next = WDOG_IDLE;
                wdog_cnt_next   = '0;
            end
        endcase
    end

    assign fifo_wdata.pc    = commit_rec_reg.pc;
    assign fifo_wdata.instr = commit_rec_reg.instr;
    assign fifo_pop         = ~fifo_empty & trace_rdy;

    core_commit_fifo #(
        .rec_t (trace_rec_x_t),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (commit_val_reg),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_ovf_reg <= 1'b0;
        end else if (commit_val_reg & fifo_full & ~fifo_pop) begin
            trace_ovf_reg <= 1'b1;
        end
    end

    assign commit_val   = commit_val_reg;
    assign commit_pc    = commit_rec_reg.pc;
    assign commit_instr = commit_rec_reg.instr;
    assign commit_rd    = commit_rec_reg.rd;
    assign commit_rd_we = commit_rec_reg.rd_we;
    assign commit_data  = commit_rec_reg.data;
    assign commit_excp  = commit_rec_reg.excp;
    assign instret      = instret_reg;
    assign hang         = (wdog_state_reg == WDOG_HANG);
    assign trace_val    = ~fifo_empty;
    // Empty storage is never shown, so the head reads 0 until a record lands.
    assign trace_pc     = fifo_empty ? '0 : fifo_rdata.pc;
    assign trace_instr  = fifo_empty ? '0 : fifo_rdata.instr;
    assign trace_ovf    = trace_ovf_reg;

endmodule

// File: tb/tb_core_commit_stage.sv
// Directed bench for the retire stage with a short watchdog limit.
module tb_core_commit_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_val;
    logic [31:0] wb_pc;
    logic [31:0] wb_instr;
    logic [4:0]  wb_rd;
    logic        wb_rd_we;
    logic [31:0] wb_data;
    logic        wb_excp;
    logic        flush;
    logic        commit_val;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic [4:0]  commit_rd;
    logic        commit_rd_we;
    logic [31:0] commit_data;
    logic        commit_excp;
    logic [63:0] instret;
    logic        hang;
    logic        trace_val;
    logic        trace_rdy;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic        trace_ovf;

    int checks = 0;
    int errors = 0;

    core_commit_stage #(
        .XLEN(32), .TRACE_DEPTH(4), .WDOG_LIMIT(8), .WDOG_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_val(wb_val), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd),
        .wb_rd_we(wb_rd_we), .wb_data(wb_data), .wb_excp(wb_excp), .flush(flush),
        .commit_val(commit_val), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_rd(commit_rd), .commit_rd_we(commit_rd_we), .commit_data(commit_data),
        .commit_excp(commit_excp), .instret(instret), .hang(hang),
        .trace_val(trace_val), .trace_rdy(trace_rdy), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .trace_ovf(trace_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wb_val = 1'b0; flush = 1'b0; wb_excp = 1'b0;
        wb_pc = '0; wb_instr = '0; wb_rd = '0; wb_rd_we = 1'b0; wb_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_wb(input logic [31:0] pc, input logic excp);
        wb_val = 1'b1; wb_pc = pc; wb_instr = 32'h0000_0013; wb_rd = 5'd2;
        wb_rd_we = 1'b1; wb_data = pc + 32'd1; wb_excp = excp;
    endtask

    task automatic test_reset();
        trace_rdy = 1'b1;
        do_reset();
        checks++;
        if ({commit_val, commit_pc, commit_rd_we, commit_excp, hang, trace_val, trace_ovf} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs val=%b pc=%h", commit_val, commit_pc);
        end
        checks++;
        if (instret !== 64'd0) begin
            errors++; $display("FAIL reset_instret: got %0d expected 0", instret);
        end
        $display("test_reset done");
    endtask

    task automatic test_idle_no_hang();
        do_reset();
        repeat (100) tick();
        checks++;
        if (hang !== 1'b0) begin
            errors++; $display("FAIL idle_hang: got %b expected 0", hang);
        end
        checks++;
        if (instret !== 64'd0 || trace_val !== 1'b0) begin
            errors++; $display("FAIL idle_state: instret %0d trace_val %b expected 0/0", instret, trace_val);
        end
        $display("test_idle_no_hang done");
    endtask

    task automatic test_basic_commit();
        do_reset();
        trace_rdy = 1'b1;
        wb_val = 1'b1; wb_pc = 32'h100; wb_instr = 32'h0050_0093;
        wb_rd = 5'd1; wb_rd_we = 1'b1; wb_data = 32'd5; wb_excp = 1'b0;
        tick();
        wb_val = 1'b0;
        checks++;
        if (commit_val !== 1'b1 || commit_pc !== 32'h100 || commit_instr !== 32'h0050_0093) begin
            errors++; $display("FAIL basic_commit: val %b pc %h instr %h expected 1 100 00500093", commit_val, commit_pc, commit_instr);
        end
        checks++;
        if (commit_rd !== 5'd1 || commit_rd_we !== 1'b1 || commit_data !== 32'd5 || commit_excp !== 1'b0) begin
            errors++; $display("FAIL basic_payload: rd %0d we %b data %0d excp %b expected 1 1 5 0", commit_rd, commit_rd_we, commit_data, commit_excp);
        end
        checks++;
        if (instret !== 64'd1 || trace_val !== 1'b0) begin
            errors++; $display("FAIL basic_instret: instret %0d trace_val %b expected 1 0", instret, trace_val);
        end
        tick();
        checks++;
        if (commit_val !== 1'b0 || commit_pc !== 32'h100) begin
            errors++; $display("FAIL basic_pulse: val %b pc %h expected 0 100", commit_val, commit_pc);
        end
        checks++;
        if (trace_val !== 1'b1 || trace_pc !== 32'h100 || trace_instr !== 32'h0050_0093) begin
            errors++; $display("FAIL basic_trace: val %b pc %h instr %h expected 1 100 00500093", trace_val, trace_pc, trace_instr);
        end
        tick();
        checks++;
        if (trace_val !== 1'b0) begin
            errors++; $display("FAIL basic_trace_pop: val %b expected 0", trace_val);
        end
        $display("test_basic_commit done");
    endtask

    task automatic test_flush();
        drive_wb(32'h180, 1'b0);
        flush = 1'b1;
        tick();
        wb_val = 1'b0; flush = 1'b0;
        checks++;
        if (commit_val !== 1'b0 || instret !== 64'd1) begin
            errors++; $display("FAIL flush_commit: val %b instret %0d expected 0 1", commit_val, instret);
        end
        tick();
        checks++;
        if (trace_val !== 1'b0 || commit_pc !== 32'h100) begin
            errors++; $display("FAIL flush_trace: trace_val %b commit_pc %h expected 0 100", trace_val, commit_pc);
        end
        $display("test_flush done");
    endtask

    task automatic test_exception();
        drive_wb(32'h1C0, 1'b1);
        tick();
        wb_val = 1'b0; wb_excp = 1'b0;
        checks++;
        if (commit_val !== 1'b1 || commit_excp !== 1'b1 || commit_rd_we !== 1'b0) begin
            errors++; $display("FAIL excp_commit: val %b excp %b rd_we %b expected 1 1 0", commit_val, commit_excp, commit_rd_we);
        end
        checks++;
        if (instret !== 64'd2 || commit_pc !== 32'h1C0) begin
            errors++; $display("FAIL excp_instret: instret %0d pc %h expected 2 1c0", instret, commit_pc);
        end
        tick();
        tick();
        $display("test_exception done");
    endtask

    task automatic test_overflow();
        do_reset();
        trace_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_wb(32'h200 + 32'(4 * i), 1'b0);
            tick();
        end
        wb_val = 1'b0;
        tick();
        tick();
        checks++;
        if (trace_ovf !== 1'b1 || instret !== 64'd5) begin
            errors++; $display("FAIL ovf_flag: ovf %b instret %0d expected 1 5", trace_ovf, instret);
        end
        trace_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (trace_val !== 1'b1 || trace_pc !== 32'h200 + 32'(4 * i)) begin
                errors++; $display("FAIL ovf_drain%0d: val %b pc %h expected 1 %h", i, trace_val, trace_pc, 32'h200 + 32'(4 * i));
            end
            tick();
        end
        checks++;
        if (trace_val !== 1'b0 || trace_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_after_drain: val %b ovf %b expected 0 1", trace_val, trace_ovf);
        end
        do_reset();
        checks++;
        if (trace_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_reset: ovf %b expected 0", trace_ovf);
        end
        $display("test_overflow done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        trace_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_wb(32'h300 + 32'(4 * i), 1'b0);
            tick();
        end
        wb_val = 1'b0;
        trace_rdy = 1'b1;
        checks++;
        if (trace_val !== 1'b1 || trace_pc !== 32'h300) begin
            errors++; $display("FAIL b2b_head: val %b pc %h expected 1 300", trace_val, trace_pc);
        end
        tick();
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (trace_val !== 1'b1 || trace_pc !== 32'h300 + 32'(4 * i)) begin
                errors++; $display("FAIL b2b_drain%0d: val %b pc %h expected 1 %h", i, trace_val, trace_pc, 32'h300 + 32'(4 * i));
            end
            tick();
        end
        checks++;
        if (trace_val !== 1'b0 || trace_ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_end: val %b ovf %b expected 0 0", trace_val, trace_ovf);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_watchdog();
        do_reset();
        drive_wb(32'h400, 1'b0);
        tick();
        wb_val = 1'b0;
        repeat (6) tick();
        checks++;
        if (hang !== 1'b0) begin
            errors++; $display("FAIL wdog_early: hang %b expected 0", hang);
        end
        tick();
        checks++;
        if (hang !== 1'b1) begin
            errors++; $display("FAIL wdog_trip: hang %b expected 1", hang);
        end
        drive_wb(32'h404, 1'b0);
        tick();
        wb_val = 1'b0;
        tick();
        checks++;
        if (hang !== 1'b1) begin
            errors++; $display("FAIL wdog_sticky: hang %b expected 1", hang);
        end
        do_reset();
        checks++;
        if (hang !== 1'b0) begin
            errors++; $display("FAIL wdog_reset: hang %b expected 0", hang);
        end
        $display("test_watchdog done");
    endtask

    task automatic test_instret_wrap();
        do_reset();
        force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_reg;
        checks++;
        if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL wrap_preload: instret %h expected ffffffffffffffff", instret);
        end
        drive_wb(32'h500, 1'b0);
        tick();
        wb_val = 1'b0;
        checks++;
        if (instret !== 64'd0 || commit_val !== 1'b1) begin
            errors++; $display("FAIL wrap: instret %h val %b expected 0 1", instret, commit_val);
        end
        $display("test_instret_wrap done");
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        drive_wb(32'h600, 1'b0);
        tick();
        drive_wb(32'h604, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0; wb_val = 1'b0;
        checks++;
        if (commit_val !== 1'b0 || instret !== 64'd0 || trace_val !== 1'b0) begin
            errors++; $display("FAIL rst_mid: val %b instret %0d trace_val %b expected 0 0 0", commit_val, instret, trace_val);
        end
        tick();
        checks++;
        if (trace_val !== 1'b0) begin
            errors++; $display("FAIL rst_mid_fifo: trace_val %b expected 0", trace_val);
        end
        $display("test_reset_mid_op done");
    endtask

    initial begin
        trace_rdy = 1'b1;
        test_reset();
        test_idle_no_hang();
        test_basic_commit();
        test_flush();
        test_exception();
        test_overflow();
        test_back_to_back();
        test_watchdog();
        test_instret_wrap();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
